// File: rtl/add_pkg.sv
// Shared definitions for the pairwise-add stage.
// Holds the default operand geometry and the result-FIFO state encoding.
package add_pkg;

   localparam int unsigned IN_W_DEF  = 7;
   localparam int unsigned PAIRS_DEF = 8;

   // Occupancy of the two-entry result buffer
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } fifo_state_e;

endpackage

// File: rtl/add_pair_lane.sv
// Single pairwise adder lane: sum_c = a + b, one bit wider than the operands.
// Operands are zero-extended (SIGNED=0) or sign-extended (SIGNED=1), so the
// result can never overflow.
// Ports: a, b (IN_W operands), sum_c (IN_W+1 combinational result).
module add_pair_lane #(
   parameter int unsigned IN_W   = 7,
   parameter int          SIGNED = 0
) (
   input  logic [IN_W-1:0] a,
   input  logic [IN_W-1:0] b,
   output logic [IN_W:0]   sum_c
);

   logic ext_a;
   logic ext_b;

   assign ext_a = (SIGNED != 0) ? a[IN_W-1] : 1'b0;
   assign ext_b = (SIGNED != 0) ? b[IN_W-1] : 1'b0;

   assign sum_c = {ext_a, a} + {ext_b, b};

endmodule

// File: rtl/add_pair_stage.sv
// Pipelined pairwise adder with a two-entry result skid buffer.
// Each input beat carries 2*PAIRS operands; the stage emits PAIRS sums of
// IN_W+1 bits, one cycle later when the buffer is empty, in acceptance order.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid/in_ready    input handshake, in_data = operands (2*PAIRS*IN_W)
//   out_valid/out_ready  output handshake, out_data = sums (PAIRS*(IN_W+1))
//   beat_cnt             16-bit count of output transfers (ADD_PAIR_CNT_EN only)
// Optional feature macro: ADD_PAIR_CNT_EN enables the beat_cnt port/counter.
module add_pair_stage
   import add_pkg::*;
#(
   parameter int unsigned IN_W   = IN_W_DEF,
   parameter int unsigned PAIRS  = PAIRS_DEF,
   parameter int          SIGNED = 0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [2*PAIRS*IN_W-1:0]      in_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [PAIRS*(IN_W+1)-1:0]    out_data
`ifdef ADD_PAIR_CNT_EN
   ,
   output logic [15:0]                  beat_cnt
`endif
);

   localparam int unsigned OW = IN_W + 1;
   localparam int unsigned RW = PAIRS * OW;

   fifo_state_e   state;
   fifo_state_e   state_n;
   logic [RW-1:0] sum_c;
   logic [RW-1:0] head;
   logic [RW-1:0] tail;
   logic          valid_q;
   logic          full_q;
   logic          push;
   logic          pop;

   // One adder per operand pair
   for (genvar i = 0; i < PAIRS; i++) begin : g_lane
      add_pair_lane #(
         .IN_W   (IN_W),
         .SIGNED (SIGNED)
      ) u_lane (
         .a     (in_data[(2*i)*IN_W +: IN_W]),
         .b     (in_data[(2*i+1)*IN_W +: IN_W]),
         .sum_c (sum_c[i*OW +: OW])
      );
   end

   // Handshake outputs come from registered flags; rst masks in_ready while held
   assign in_ready  = ~full_q & ~rst;
   assign out_valid = valid_q;
   assign out_data  = head;

   assign push = in_valid & in_ready;
   assign pop  = valid_q & out_ready;

   // FIFO occupancy register
   always_ff @(posedge clk) begin
      if (rst) state <= EMPTY;
      else     state <= state_n;
   end

   // Next-state logic
   always_comb begin
      state_n = state;
      case (state)
         EMPTY: if (push) state_n = ONE;
         ONE: begin
            if (push && !pop)      state_n = FULL;
            else if (!push && pop) state_n = EMPTY;
         end
         FULL:    if (pop) state_n = ONE;
         default: state_n = EMPTY;
      endcase
   end

   // Result storage: head is always the oldest beat, tail the second one
   always_ff @(posedge clk) begin
      if (rst) begin
         head    <= '0;
         tail    <= '0;
         valid_q <= 1'b0;
         full_q  <= 1'b0;
      end else begin
         valid_q <= (state_n != EMPTY);
         full_q  <= (state_n == FULL);
         case (state)
            EMPTY: if (push) head <= sum_c;
            ONE: begin
               if (push && pop) head <= sum_c;
               else if (push)   tail <= sum_c;
            end
            FULL:    if (pop) head <= tail;
            default: ;
         endcase
      end
   end

`ifdef ADD_PAIR_CNT_EN
   logic [15:0] cnt;

   // Output-transfer counter, wraps naturally at 16 bits
   always_ff @(posedge clk) begin
      if (rst)      cnt <= 16'd0;
      else if (pop) cnt <= cnt + 16'd1;
   end

   assign beat_cnt = cnt;
`endif

endmodule

// File: doc/add_pair_stage.md
ADD_PAIR_STAGE -- requirements
Module: add_pair_stage

Interface
REQ-001 Parameter IN_W, default 7, operand width in bits (>=1).
REQ-002 Parameter PAIRS, default 8, number of independent operand pairs (>=1).
REQ-003 Parameter SIGNED, default 0, 0 = unsigned operands, 1 = two's-complement operands.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  in_data holds a beat.
REQ-007 in_ready  output  1  stage accepts a beat this cycle.
REQ-008 in_data  input  2*PAIRS*IN_W  operand j at bits [j*IN_W +: IN_W], j = 0..2*PAIRS-1.
REQ-009 out_valid  output  1  out_data holds a result beat.
REQ-010 out_ready  input  1  downstream accepts a result beat this cycle.
REQ-011 out_data  output  PAIRS*(IN_W+1)  sum i at bits [i*(IN_W+1) +: IN_W+1].
REQ-012 beat_cnt  output  16  completed output transfers; present only with ADD_PAIR_CNT_EN.

Function
REQ-013 Input transfer occurs when in_valid && in_ready; output transfer when out_valid && out_ready.
REQ-014 Sum i SHALL equal op[2i] + op[2i+1], computed at IN_W+1 bits: zero-extended when SIGNED=0, sign-extended when SIGNED=1; no overflow or truncation is possible.
REQ-015 Latency: a beat accepted in cycle N appears on out_data with out_valid=1 in cycle N+1 when the buffer was empty.
REQ-016 Storage: 2-entry result FIFO (skid buffer); states EMPTY, ONE, FULL.
REQ-017 in_ready SHALL be 1 in EMPTY and ONE, 0 in FULL, and SHALL depend only on registered state (no combinational path from out_ready).
REQ-018 Transitions: EMPTY->ONE on input transfer; ONE->FULL on input without output; ONE->EMPTY on output without input; FULL->ONE on output; simultaneous input and output in ONE stays in ONE.
REQ-019 Beats SHALL leave in acceptance order; none dropped or duplicated.
REQ-020 out_data and out_valid SHALL remain stable while out_valid=1 and out_ready=0.
REQ-021 in_data is ignored when in_valid=0 or in_ready=0.

Reset
REQ-022 While rst=1: state EMPTY, out_valid=0, in_ready=0, out_data=0, beat_cnt=0.
REQ-023 In the first cycle after rst falls, in_ready=1.
REQ-024 Reset mid-operation discards all buffered beats; no beat stored before reset is ever presented.

Configuration
REQ-025 Macro ADD_PAIR_CNT_EN defined: beat_cnt port exists, increments by 1 per output transfer, wraps 0xFFFF->0x0000, holds otherwise.
REQ-026 Macro ADD_PAIR_CNT_EN undefined: beat_cnt port and counter logic absent; all other behaviour identical.

Structure
REQ-027 Shared package add_pkg SHALL hold the FIFO state enum (EMPTY/ONE/FULL) and the default constants IN_W=7, PAIRS=8.
REQ-028 One sub-module add_pair_lane (single parametrised IN_W-bit pairwise adder, combinational, IN_W+1-bit result), instantiated PAIRS times by generate.

Verification
REQ-029 IN_W=7, PAIRS=8, SIGNED=0: every operand 0x7F, out_ready=1 -> next cycle all 8 sums 0xFE, out_valid=1.
REQ-030 SIGNED=1: pair (0x40, 0x40) -> 0x80 (-128); pair (0x3F, 0x01) -> 0x040 (+64); pair (0x7F, 0x01) -> 0x00.
REQ-031 out_ready=0, three consecutive beats offered -> first two accepted, in_ready=0 on third; release out_ready -> beats 1, 2 out in order, then third accepted.
REQ-032 Continuous in_valid=1, out_ready=1 for 100 beats -> one result per cycle, in_ready never drops, order preserved.
REQ-033 FULL buffer, assert rst for one cycle -> out_valid=0 next cycle, stale beats never appear, beat_cnt=0.
REQ-034 ADD_PAIR_CNT_EN defined, counter preloaded to 0xFFFF via 65535 transfers -> one more transfer yields beat_cnt=0x0000.
